// File: rtl/algo_track_pkg.sv
// Shared widths and FSM encoding for the hue-centroid tracker.
package algo_track_pkg;

    localparam int unsigned COORD_W_DEF = 11;

    // Pixel-count width: enough for a full 2^COORD_W x 2^COORD_W frame.
    function automatic int unsigned cnt_w(input int unsigned coord_w);
        return 2 * coord_w;
    endfunction

    // Coordinate-sum width: count width plus one coordinate.
    function automatic int unsigned sum_w(input int unsigned coord_w);
        return 3 * coord_w;
    endfunction

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DIV   = 2'd1,
        ST_EMPTY = 2'd2,
        ST_DONE  = 2'd3
    } hc_state_e;

endpackage

// File: rtl/algo_seq_div.sv
// Restoring unsigned divider, one quotient bit per clock.
// start_i loads the operands (and restarts a division in progress);
// done_o pulses for one cycle after DIVIDEND_W iterations.
module algo_seq_div
    import algo_track_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = 33,
    parameter int unsigned DIVISOR_W  = 22,
    parameter int unsigned QUO_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [DIVIDEND_W-1:0] dividend_i,
    input  logic [DIVISOR_W-1:0]  divisor_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [QUO_W-1:0]      quotient_o
);

    localparam int unsigned STEP_W = $clog2(DIVIDEND_W + 1);

    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  den_q;
    logic [STEP_W-1:0]     step_q;
    logic                  busy_q;
    logic                  done_q;

    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    trial;
    logic                  take;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // The borrow bit of the trial subtraction decides the quotient bit.
    always_comb begin
        shifted = {rem_q, quo_q[DIVIDEND_W-1]};
        trial   = shifted - {1'b0, den_q};
        take    = ~trial[DIVISOR_W];
        rem_d   = take ? trial[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
        quo_d   = {quo_q[DIVIDEND_W-2:0], take};
    end

    // Iteration state; start has priority so a new request aborts the old one.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            den_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                rem_q  <= '0;
                quo_q  <= dividend_i;
                den_q  <= divisor_i;
                step_q <= STEP_W'(DIVIDEND_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_d;
                quo_q  <= quo_d;
                step_q <= step_q - STEP_W'(1);
                if (step_q == STEP_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q[QUO_W-1:0];

endmodule

// File: rtl/algo_hue_centroid.sv
// Hue-window target classifier with per-frame bounding box, pixel count
// and centroid. Result is registered and strobed once per frame.
module algo_hue_centroid
    import algo_track_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter logic [7:0]  HUE_MIN = 8'd1,
    parameter logic [7:0]  HUE_MAX = 8'd255,
    parameter int unsigned MIN_PIX = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_vs,
    input  logic                        i_hs,
    input  logic                        i_data_en,
    input  logic [7:0]                  i_hue,
    output logic                        o_valid,
    output logic                        o_found,
    output logic [COORD_W-1:0]          o_x_min,
    output logic [COORD_W-1:0]          o_x_max,
    output logic [COORD_W-1:0]          o_y_min,
    output logic [COORD_W-1:0]          o_y_max,
    output logic [COORD_W-1:0]          o_x_cen,
    output logic [COORD_W-1:0]          o_y_cen,
    output logic [cnt_w(COORD_W)-1:0]   o_pix_cnt
);

    localparam int unsigned CNT_W = cnt_w(COORD_W);
    localparam int unsigned SUM_W = sum_w(COORD_W);
    localparam logic [CNT_W-1:0] MIN_PIX_C = CNT_W'(MIN_PIX);

    // Edge detection
    logic vs_q, hs_q;
    logic t0, hs_fall;

    // Pixel position
    logic [COORD_W-1:0] x_q, y_q;

    // Running statistics for the frame in progress
    logic [CNT_W-1:0]   cnt_q;
    logic [SUM_W-1:0]   sum_x_q, sum_y_q;
    logic [COORD_W-1:0] xmin_q, xmax_q, ymin_q, ymax_q;

    // Snapshot of the finished frame
    logic               h_found_q;
    logic [CNT_W-1:0]   h_cnt_q;
    logic [COORD_W-1:0] h_xmin_q, h_xmax_q, h_ymin_q, h_ymax_q;

    // Registered outputs
    logic               valid_q, found_q;
    logic [COORD_W-1:0] oxmin_q, oxmax_q, oymin_q, oymax_q, oxcen_q, oycen_q;
    logic [CNT_W-1:0]   opcnt_q;

    // FSM
    hc_state_e state_q, state_d;
    logic      load_out;

    // Dividers
    logic               div_start;
    logic               busy_x, busy_y, done_x, done_y;
    logic [COORD_W-1:0] quo_x, quo_y;

    logic hue_ok, pix_hit, found_now;

    assign t0        = i_vs & ~vs_q;
    assign hs_fall   = hs_q & ~i_hs;
    assign hue_ok    = ({1'b0, i_hue} >= {1'b0, HUE_MIN}) &&
                       ({1'b0, i_hue} <= {1'b0, HUE_MAX});
    assign pix_hit   = i_data_en & ~i_vs & hue_ok;
    assign found_now = (cnt_q >= MIN_PIX_C);
    assign div_start = t0 & found_now;

    // Previous-cycle sync levels for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q <= 1'b0;
            hs_q <= 1'b0;
        end else begin
            vs_q <= i_vs;
            hs_q <= i_hs;
        end
    end

    // Column/line counters; both wrap naturally at 2^COORD_W
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            if (hs_fall)
                x_q <= '0;
            else if (i_data_en)
                x_q <= x_q + COORD_W'(1);

            if (t0)
                y_q <= '0;
            else if (hs_fall)
                y_q <= y_q + COORD_W'(1);
        end
    end

    // Target accumulation, using the column before this pixel's increment
    always_ff @(posedge clk) begin
        if (rst || t0) begin
            cnt_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
            xmin_q  <= '1;
            xmax_q  <= '0;
            ymin_q  <= '1;
            ymax_q  <= '0;
        end else if (pix_hit) begin
            cnt_q   <= cnt_q + CNT_W'(1);
            sum_x_q <= sum_x_q + SUM_W'(x_q);
            sum_y_q <= sum_y_q + SUM_W'(y_q);
            if (x_q < xmin_q) xmin_q <= x_q;
            if (x_q > xmax_q) xmax_q <= x_q;
            if (y_q < ymin_q) ymin_q <= y_q;
            if (y_q > ymax_q) ymax_q <= y_q;
        end
    end

    // Frame snapshot; sums go straight into the dividers at the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            h_found_q <= 1'b0;
            h_cnt_q   <= '0;
            h_xmin_q  <= '0;
            h_xmax_q  <= '0;
            h_ymin_q  <= '0;
            h_ymax_q  <= '0;
        end else if (t0) begin
            h_found_q <= found_now;
            h_cnt_q   <= cnt_q;
            h_xmin_q  <= xmin_q;
            h_xmax_q  <= xmax_q;
            h_ymin_q  <= ymin_q;
            h_ymax_q  <= ymax_q;
        end
    end

    algo_seq_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUO_W      (COORD_W)
    ) u_div_x (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (sum_x_q),
        .divisor_i  (cnt_q),
        .busy_o     (busy_x),
        .done_o     (done_x),
        .quotient_o (quo_x)
    );

    algo_seq_div #(
        .DIVIDEND_W (SUM_W),
        .DIVISOR_W  (CNT_W),
        .QUO_W      (COORD_W)
    ) u_div_y (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .dividend_i (sum_y_q),
        .divisor_i  (cnt_q),
        .busy_o     (busy_y),
        .done_o     (done_y),
        .quotient_o (quo_y)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_ACCUM;
        else
            state_q <= state_d;
    end

    // Next state and output load; a frame boundary overrides any state,
    // which discards an unfinished division without a strobe
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        unique case (state_q)
            ST_ACCUM: state_d = ST_ACCUM;
            ST_DIV: begin
                if (done_x && done_y && !busy_x && !busy_y)
                    state_d = ST_DONE;
            end
            ST_EMPTY: state_d = ST_DONE;
            ST_DONE: begin
                load_out = 1'b1;
                state_d  = ST_ACCUM;
            end
            default: state_d = ST_ACCUM;
        endcase
        if (t0)
            state_d = found_now ? ST_DIV : ST_EMPTY;
    end

    // Result registers; hold between strobes, zero box/centroid when not found
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            found_q <= 1'b0;
            oxmin_q <= '0;
            oxmax_q <= '0;
            oymin_q <= '0;
            oymax_q <= '0;
            oxcen_q <= '0;
            oycen_q <= '0;
            opcnt_q <= '0;
        end else begin
            valid_q <= load_out;
            if (load_out) begin
                found_q <= h_found_q;
                oxmin_q <= h_found_q ? h_xmin_q : '0;
                oxmax_q <= h_found_q ? h_xmax_q : '0;
                oymin_q <= h_found_q ? h_ymin_q : '0;
                oymax_q <= h_found_q ? h_ymax_q : '0;
                oxcen_q <= h_found_q ? quo_x    : '0;
                oycen_q <= h_found_q ? quo_y    : '0;
                opcnt_q <= h_cnt_q;
            end
        end
    end

    assign o_valid   = valid_q;
    assign o_found   = found_q;
    assign o_x_min   = oxmin_q;
    assign o_x_max   = oxmax_q;
    assign o_y_min   = oymin_q;
    assign o_y_max   = oymax_q;
    assign o_x_cen   = oxcen_q;
    assign o_y_cen   = oycen_q;
    assign o_pix_cnt = opcnt_q;

endmodule

// File: tb/tb_algo_hue_centroid.sv
// Scoreboard bench for algo_hue_centroid: frames are generated with
// directed and random hue patterns, expected per-frame statistics are
// queued by the driver, and a negedge monitor checks each result strobe.
`timescale 1ns/1ps
module tb_algo_hue_centroid;

    localparam int unsigned CW        = 11;
    localparam int unsigned HMIN      = 50;
    localparam int unsigned HMAX      = 60;
    localparam int unsigned MINP      = 2;
    localparam int unsigned LAT_DIV   = 3 * CW + 2;
    localparam int unsigned LAT_EMPTY = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            i_vs = 1'b0, i_hs = 1'b0, i_data_en = 1'b0;
    logic [7:0]      i_hue = 8'd0;
    logic            o_valid, o_found;
    logic [CW-1:0]   o_x_min, o_x_max, o_y_min, o_y_max, o_x_cen, o_y_cen;
    logic [2*CW-1:0] o_pix_cnt;

    always #5 clk = ~clk;

    algo_hue_centroid #(
        .COORD_W (CW),
        .HUE_MIN (8'd50),
        .HUE_MAX (8'd60),
        .MIN_PIX (MINP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_vs      (i_vs),
        .i_hs      (i_hs),
        .i_data_en (i_data_en),
        .i_hue     (i_hue),
        .o_valid   (o_valid),
        .o_found   (o_found),
        .o_x_min   (o_x_min),
        .o_x_max   (o_x_max),
        .o_y_min   (o_y_min),
        .o_y_max   (o_y_max),
        .o_x_cen   (o_x_cen),
        .o_y_cen   (o_y_cen),
        .o_pix_cnt (o_pix_cnt)
    );

    typedef struct {
        longint found;
        longint xmin, xmax, ymin, ymax, xcen, ycen, cnt;
        longint due;
    } exp_t;

    exp_t   sb[$];
    exp_t   cur;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     lines_since_t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every strobe must match the oldest queued frame at its due cycle
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", o_valid, 0);
            end else begin
                cur = sb.pop_front();
                chk("latency", cyc, cur.due);
                chk("found", o_found, cur.found);
                chk("x_min", o_x_min, cur.xmin);
                chk("x_max", o_x_max, cur.xmax);
                chk("y_min", o_y_min, cur.ymin);
                chk("y_max", o_y_max, cur.ymax);
                chk("x_cen", o_x_cen, cur.xcen);
                chk("y_cen", o_y_cen, cur.ycen);
                chk("pix_cnt", o_pix_cnt, cur.cnt);
            end
        end else if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("valid_timeout", o_valid, 1);
            void'(sb.pop_front());
        end
    end

    function automatic logic [7:0] hue_for(input int mode, input int x, input int y);
        case (mode)
            0: return 8'($urandom_range(30, 80));
            1: return (x == 5 && y == 2) ? 8'd55 : 8'd0;
            2: return (x >= 2 && x <= 4 && y >= 1 && y <= 2) ? 8'd55 : 8'd0;
            3: return 8'($urandom_range(0, 49));
            4: begin
                if (y != 0) return 8'd0;
                case (x)
                    0: return 8'd49;
                    1: return 8'd50;
                    2: return 8'd60;
                    3: return 8'd61;
                    default: return 8'd0;
                endcase
            end
            5: return 8'd55;
            6: return 8'($urandom_range(0, 255));
            7: return (y == 2 && (x == 5 || x == 6)) ? 8'd55 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    // Drive the active region of one frame, then raise vsync (frame boundary).
    task automatic drive_frame(input int w, input int h, input int mode,
                               input bit gaps, input bit expect_res);
        longint cnt = 0, sx = 0, sy = 0;
        longint xmn = 0, xmx = 0, ymn = 0, ymx = 0;
        int x, y;
        logic [7:0] hv;
        exp_t e;
        for (int l = 0; l < h; l++) begin
            y = lines_since_t0;
            x = 0;
            while (x < w) begin
                @(posedge clk); #1;
                i_hs = 1'b1;
                if (gaps && $urandom_range(0, 3) == 0) begin
                    i_data_en = 1'b0;
                    i_hue     = 8'($urandom);
                end else begin
                    hv        = hue_for(mode, x, y);
                    i_data_en = 1'b1;
                    i_hue     = hv;
                    if (hv >= HMIN && hv <= HMAX) begin
                        if (cnt == 0 || x < xmn) xmn = x;
                        if (cnt == 0 || x > xmx) xmx = x;
                        if (cnt == 0 || y < ymn) ymn = y;
                        if (cnt == 0 || y > ymx) ymx = y;
                        cnt++;
                        sx += x;
                        sy += y;
                    end
                    x++;
                end
            end
            repeat (3) begin
                @(posedge clk); #1;
                i_hs = 1'b0; i_data_en = 1'b0; i_hue = 8'd0;
            end
            lines_since_t0++;
        end
        @(posedge clk); #1;
        i_vs = 1'b1;
        lines_since_t0 = 0;
        if (expect_res) begin
            e.cnt   = cnt;
            e.found = (cnt >= MINP) ? 1 : 0;
            e.xmin  = e.found ? xmn : 0;
            e.xmax  = e.found ? xmx : 0;
            e.ymin  = e.found ? ymn : 0;
            e.ymax  = e.found ? ymx : 0;
            e.xcen  = e.found ? sx / cnt : 0;
            e.ycen  = e.found ? sy / cnt : 0;
            e.due   = cyc + 1 + (e.found ? LAT_DIV : LAT_EMPTY);
            sb.push_back(e);
        end
    endtask

    // Hold vsync for n cycles; optional burst of in-window pixels during
    // blanking, which must not be counted (its hsync fall still bumps y).
    task automatic blank(input int n, input bit burst);
        if (burst) begin
            repeat (3) begin
                @(posedge clk); #1;
                i_hs = 1'b1; i_data_en = 1'b1; i_hue = 8'd55;
            end
            @(posedge clk); #1;
            i_hs = 1'b0; i_data_en = 1'b0; i_hue = 8'd0;
            lines_since_t0++;
        end
        repeat (n) @(posedge clk);
        #1;
        i_vs = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_found"}, o_found, 0);
        chk({tag, "_x_min"}, o_x_min, 0);
        chk({tag, "_x_max"}, o_x_max, 0);
        chk({tag, "_y_min"}, o_y_min, 0);
        chk({tag, "_y_max"}, o_y_max, 0);
        chk({tag, "_x_cen"}, o_x_cen, 0);
        chk({tag, "_y_cen"}, o_y_cen, 0);
        chk({tag, "_pix_cnt"}, o_pix_cnt, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Directed frames: below/at count threshold, rectangle, empty, hue edges
        drive_frame(8, 4, 1, 1'b0, 1'b1); blank(40, 1'b0);
        drive_frame(8, 4, 7, 1'b0, 1'b1); blank(40, 1'b0);
        drive_frame(8, 4, 2, 1'b0, 1'b1); blank(40, 1'b0);
        drive_frame(8, 4, 3, 1'b0, 1'b1); blank(40, 1'b0);
        drive_frame(8, 4, 4, 1'b0, 1'b1); blank(40, 1'b0);

        // Random frames, one with ignored blanking pixels
        drive_frame(24, 10, 0, 1'b1, 1'b1); blank(40, 1'b1);
        drive_frame(24, 10, 0, 1'b1, 1'b1); blank(40, 1'b0);
        drive_frame(3, 2, 6, 1'b1, 1'b1);   blank(40, 1'b0);
        drive_frame(20, 6, 0, 1'b1, 1'b1);  blank(40, 1'b0);

        // Second boundary 10 cycles after the first: only the second reports
        drive_frame(8, 4, 5, 1'b0, 1'b0); blank(2, 1'b0);
        drive_frame(4, 1, 5, 1'b0, 1'b1); blank(40, 1'b0);

        // Reset while dividing: outputs clear, no strobe for that frame
        drive_frame(8, 4, 2, 1'b0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1; i_vs = 1'b0;
        lines_since_t0 = 0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst");
        rst = 1'b0;
        repeat (40) @(posedge clk);

        // Normal operation after reset
        drive_frame(16, 8, 0, 1'b1, 1'b1); blank(40, 1'b0);
        drive_frame(8, 4, 2, 1'b0, 1'b1);  blank(40, 1'b0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        chk("pending_results", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
